apb_regfile_slave: RTL and testbench
====================================

# apb_regfile_slave

Parametrised APB3 slave register bank, the successor to the team's fixed four-register APB slave. It provides NUM_REGS registers of DATA_WIDTH bits, byte-strobe writes, per-register read-only protection, a programmable number of wait states and PSLVERR signalling. It sits on the APB peripheral bus behind the bridge, and exposes all register contents to local logic.

## Interface
Parameters:
- DATA_WIDTH, 32: register/bus width; one of 8, 16, 32, 64. BYTES = DATA_WIDTH/8.
- ADDR_WIDTH, 32: PADDR width.
- NUM_REGS, 4: number of registers, 1..256.
- WAIT_STATES, 0: extra PREADY-low access cycles, 0..15.
- RO_MASK, {NUM_REGS{1'b0}}: bit i = 1 makes register i read-only.

Ports:
- PCLK  in  1  clock; all state changes on rising edge.
- PRESET  in  1  reset; asynchronous and active-high.
- PSEL  in  1  slave select.
- PENABLE  in  1  access phase.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_WIDTH  byte address, offset from slave base.
- PWDATA  in  DATA_WIDTH  write data.
- PSTRB  in  BYTES  byte-lane write enables.
- PRDATA  out  DATA_WIDTH  read data, registered.
- PREADY  out  1  transfer-complete, registered.
- PSLVERR  out  1  error response, valid while PREADY = 1.
- regs_o  out  NUM_REGS*DATA_WIDTH  all register contents; register i is at slice [i*DATA_WIDTH +: DATA_WIDTH].

## Operation
- Register i is at byte offset i*BYTES. idx = PADDR / BYTES.
- A transfer is an error if any of these holds:
  - PADDR is misaligned (PADDR % BYTES != 0);
  - idx >= NUM_REGS;
  - the transfer is a write and RO_MASK[idx] = 1.
- A legal write updates only the bytes whose PSTRB bit is 1. PSTRB = 0 is legal and changes nothing.
- An error write changes no register.
- A read returns register idx on PRDATA. An error read returns 0.
- PRDATA holds its value until the next completed read.
- FSM states:
  - IDLE: on an edge with PSEL=1 and PENABLE=0 (setup), go to WAIT and load cnt = WAIT_STATES.
  - WAIT: on an edge with PSEL=1 and PENABLE=1, if cnt != 0 then decrement cnt. If cnt = 0, commit the write or capture the read, set PREADY <= 1 and PSLVERR <= err, and go to RESP.
  - RESP: PREADY = 1 for exactly one cycle. On the next edge set PREADY <= 0 and PSLVERR <= 0, then go to IDLE.
- Abort: PSEL = 0 while in WAIT returns the FSM to IDLE with no commit and no response.
- PADDR, PWRITE, PWDATA and PSTRB are sampled at the commit edge.
- Reset values:
  - PRDATA = 0, PREADY = 0, PSLVERR = 0;
  - all registers = 0, regs_o = 0;
  - state = IDLE, cnt = 0.
- Reset asserted mid-transfer clears everything to reset values immediately (asynchronously). The in-flight transfer is dropped.

## Timing
- Cycle numbering for a transfer: setup cycle = C0; access starts at C1.
- PREADY is low for WAIT_STATES+1 access cycles, then high for one cycle.
- Total transfer length: WAIT_STATES+3 cycles (setup, WAIT_STATES+1 low, one high).
- The write is committed, and regs_o updated, at the edge that raises PREADY.
- The transfer completes on the APB at the following edge.
- Back-to-back transfers: the next setup may begin the cycle after completion. There are no idle bubbles beyond that.
- cnt is 4 bits wide and never wraps (WAIT_STATES <= 15).

## Structure
- Package apb_regfile_pkg holds:
  - the state enum {ST_IDLE, ST_WAIT, ST_RESP};
  - a function that decodes address to index plus error flag.
- One natural sub-module: apb_reg_bank. It holds NUM_REGS x DATA_WIDTH storage and applies the per-byte strobe write.
- The FSM, counter and response path stay in the top module.

## Test plan
- WAIT_STATES=0, write 0xDEADBEEF to 0x4 with PSTRB=4'hF, then read 0x4 -> PREADY high at C2, PRDATA=0xDEADBEEF, PSLVERR=0, regs_o slice 1 = 0xDEADBEEF.
- Write 0x11223344 to 0x8 with PSTRB=4'hF, then 0xAABBCCDD with PSTRB=4'b0101 -> register 2 reads 0x11BB33DD.
- RO_MASK=4'b0001, write 0x5 to 0x0 -> PSLVERR=1, register 0 stays 0. Read 0x10 (idx 4) -> PSLVERR=1, PRDATA=0. Write to 0x2 (misaligned) -> PSLVERR=1.
- WAIT_STATES=3 -> PREADY low for 4 access cycles, high on the 5th. Back-to-back write then read completes in 12 cycles.
- PRESET pulsed during WAIT of a write to 0xC -> PREADY=0 immediately, register 3 = 0, and a subsequent normal read of 0xC returns 0.
- PSEL dropped mid-WAIT -> no PREADY pulse, no register change; the next transfer behaves normally.

Source files
------------

// File: rtl/apb_regfile_pkg.sv
// rtl/apb_regfile_pkg.sv - shared types and address decode for the APB register bank
package apb_regfile_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    typedef struct packed {
        logic [7:0] idx;
        logic       err;
    } decode_t;

    // err covers misalignment and out-of-range; read-only checks need the access type
    function automatic decode_t decode_addr(input logic [63:0] addr,
                                            input int unsigned lsb,
                                            input int unsigned num_regs);
        decode_t     d;
        logic [63:0] q;
        logic [63:0] mask;
        q     = addr >> lsb;
        mask  = (64'd1 << lsb) - 64'd1;
        d.idx = q[7:0];
        d.err = ((addr & mask) != 64'd0) || (q >= 64'(num_regs));
        return d;
    endfunction

endpackage

// File: rtl/apb_regfile_slave_if.sv
// rtl/apb_regfile_slave_if.sv - APB3 bus bundle for the register bank slave
interface apb_regfile_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    psel;
    logic                    penable;
    logic                    pwrite;
    logic [ADDR_WIDTH-1:0]   paddr;
    logic [DATA_WIDTH-1:0]   pwdata;
    logic [DATA_WIDTH/8-1:0] pstrb;
    logic [DATA_WIDTH-1:0]   prdata;
    logic                    pready;
    logic                    pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_reg_bank.sv
// rtl/apb_reg_bank.sv - register storage with per-byte strobe writes and a read mux
module apb_reg_bank #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           we,
    input  logic [7:0]                     idx,
    input  logic [DATA_WIDTH-1:0]          wdata,
    input  logic [DATA_WIDTH/8-1:0]        strb,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs
);
    localparam int BYTES = DATA_WIDTH / 8;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs <= '0;
        end else if (we) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                for (int b = 0; b < BYTES; b++) begin
                    if (idx == 8'(i) && strb[b])
                        regs[i*DATA_WIDTH + b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx == 8'(i))
                rdata = regs[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

endmodule

// File: rtl/apb_regfile_slave.sv
// rtl/apb_regfile_slave.sv - parametrised APB3 register bank slave with wait states and PSLVERR
module apb_regfile_slave
    import apb_regfile_pkg::*;
#(
    parameter int                DATA_WIDTH  = 32,
    parameter int                ADDR_WIDTH  = 32,
    parameter int                NUM_REGS    = 4,
    parameter int                WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0] RO_MASK   = '0
) (
    input  logic                           pclk,
    input  logic                           preset,
    apb_regfile_slave_if.slave             bus,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);
    localparam int unsigned LSB = $clog2(DATA_WIDTH / 8);

    state_t                  state, state_next;
    logic [3:0]              cnt, cnt_next;
    logic [DATA_WIDTH-1:0]   prdata_q, prdata_next, rdata;
    logic                    pready_q, pready_next;
    logic                    pslverr_q, pslverr_next;
    logic                    commit, err, bank_we;
    decode_t                 dec;
    logic [255:0]            ro_ext;

    assign ro_ext = 256'(RO_MASK);
    assign dec    = decode_addr(64'(bus.paddr), LSB, NUM_REGS);
    assign err    = dec.err || (bus.pwrite && ro_ext[dec.idx]);

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            prdata_q  <= prdata_next;
            pready_q  <= pready_next;
            pslverr_q <= pslverr_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            ST_IDLE: begin
                if (bus.psel && !bus.penable) begin
                    state_next = ST_WAIT;
                    cnt_next   = 4'(WAIT_STATES);
                end
            end
            ST_WAIT: begin
                if (!bus.psel) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else if (bus.penable) begin
                    if (cnt != 4'd0) cnt_next   = cnt - 4'd1;
                    else             state_next = ST_RESP;
                end
            end
            ST_RESP:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // PRDATA only moves on a completed read; write responses leave it untouched
    always_comb begin
        commit       = (state == ST_WAIT) && bus.psel && bus.penable && (cnt == 4'd0);
        bank_we      = commit && bus.pwrite && !err;
        pready_next  = commit;
        pslverr_next = commit && err;
        prdata_next  = prdata_q;
        if (commit && !bus.pwrite)
            prdata_next = err ? '0 : rdata;
    end

    apb_reg_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_bank (
        .clk   (pclk),
        .rst   (preset),
        .we    (bank_we),
        .idx   (dec.idx),
        .wdata (bus.pwdata),
        .strb  (bus.pstrb),
        .rdata (rdata),
        .regs  (regs_o)
    );

    assign bus.prdata  = prdata_q;
    assign bus.pready  = pready_q;
    assign bus.pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_regfile_slave.sv
// tb/tb_apb_regfile_slave.sv - scoreboard bench for apb_regfile_slave with two configurations
module tb_apb_regfile_slave;
    import apb_regfile_pkg::*;

    typedef struct {
        logic        rd;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic          clk;
    logic          rst_a, rst_b;
    logic [127:0]  regs_a, regs_b;
    int            errors, checks, cyc;
    bit            done;
    exp_t          qa[$], qb[$];

    apb_regfile_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) ifa();
    apb_regfile_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) ifb();

    apb_regfile_slave #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_REGS(4), .WAIT_STATES(0), .RO_MASK(4'b0001)
    ) dut_a (.pclk(clk), .preset(rst_a), .bus(ifa), .regs_o(regs_a));

    apb_regfile_slave #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_REGS(4), .WAIT_STATES(3), .RO_MASK(4'b0000)
    ) dut_b (.pclk(clk), .preset(rst_b), .bus(ifb), .regs_o(regs_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic rdy(input bit d);
        return d ? ifb.pready : ifa.pready;
    endfunction

    task automatic drive(input bit d, input logic sel, input logic en, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb);
        if (d) begin
            ifb.psel = sel; ifb.penable = en; ifb.pwrite = wr;
            ifb.paddr = addr; ifb.pwdata = wdata; ifb.pstrb = strb;
        end else begin
            ifa.psel = sel; ifa.penable = en; ifa.pwrite = wr;
            ifa.paddr = addr; ifa.pwdata = wdata; ifa.pstrb = strb;
        end
    endtask

    // Leaves PSEL high after completion so a following call starts back-to-back
    task automatic apb_xfer(input bit d, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] strb,
                            input logic [31:0] exp_data, input logic exp_err, input int exp_lat);
        exp_t e;
        int   lat;
        e.rd = !wr; e.data = exp_data; e.err = exp_err;
        if (d) qb.push_back(e); else qa.push_back(e);
        drive(d, 1'b1, 1'b0, wr, addr, wdata, strb);
        @(posedge clk); #1;
        drive(d, 1'b1, 1'b1, wr, addr, wdata, strb);
        lat = 1;
        while (rdy(d) !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("pready_cycle", 128'(lat), 128'(exp_lat));
        @(posedge clk); #1;
    endtask

    task automatic mon(input bit d);
        exp_t e;
        if (rdy(d) === 1'b1) begin
            if ((d ? qb.size() : qa.size()) == 0) begin
                chk(d ? "unexpected_pready_b" : "unexpected_pready_a", 128'(1), 128'(0));
            end else begin
                e = d ? qb.pop_front() : qa.pop_front();
                chk(d ? "pslverr_b" : "pslverr_a", 128'(d ? ifb.pslverr : ifa.pslverr), 128'(e.err));
                if (e.rd)
                    chk(d ? "prdata_b" : "prdata_a", 128'(d ? ifb.prdata : ifa.prdata), 128'(e.data));
            end
        end
    endtask

    initial begin
        int t0;
        errors = 0; checks = 0; done = 1'b0;
        rst_a = 1'b1; rst_b = 1'b1;
        drive(0, 0, 0, 0, 32'h0, 32'h0, 4'h0);
        drive(1, 0, 0, 0, 32'h0, 32'h0, 4'h0);
        fork
            begin
                while (!done) begin
                    @(negedge clk);
                    mon(0);
                    mon(1);
                end
            end
            begin
                @(negedge clk); @(negedge clk);
                chk("rst_prdata_a", 128'(ifa.prdata), 128'(0));
                chk("rst_pready_a", 128'(ifa.pready), 128'(0));
                chk("rst_pslverr_a", 128'(ifa.pslverr), 128'(0));
                chk("rst_regs_a", regs_a, 128'(0));
                chk("rst_regs_b", regs_b, 128'(0));
                @(posedge clk); #1;
                rst_a = 1'b0; rst_b = 1'b0;
                @(posedge clk); #1;

                // no wait states, reg0 read-only
                apb_xfer(0, 1, 32'h4, 32'hDEADBEEF, 4'hF, 32'h0, 0, 2);
                chk("regs_a_slice1", 128'(regs_a[63:32]), 128'(32'hDEADBEEF));
                apb_xfer(0, 0, 32'h4, 32'h0, 4'h0, 32'hDEADBEEF, 0, 2);
                apb_xfer(0, 1, 32'h8, 32'h11223344, 4'hF, 32'h0, 0, 2);
                apb_xfer(0, 1, 32'h8, 32'hAABBCCDD, 4'b0101, 32'h0, 0, 2);
                apb_xfer(0, 1, 32'h8, 32'hFFFFFFFF, 4'h0, 32'h0, 0, 2);
                apb_xfer(0, 0, 32'h8, 32'h0, 4'h0, 32'h11BB33DD, 0, 2);
                apb_xfer(0, 1, 32'h0, 32'h5, 4'hF, 32'h0, 1, 2);
                chk("ro_reg0_unchanged", 128'(regs_a[31:0]), 128'(0));
                apb_xfer(0, 0, 32'h10, 32'h0, 4'h0, 32'h0, 1, 2);
                apb_xfer(0, 0, 32'h4, 32'h0, 4'h0, 32'hDEADBEEF, 0, 2);
                apb_xfer(0, 0, 32'h6, 32'h0, 4'h0, 32'h0, 1, 2);
                apb_xfer(0, 1, 32'h2, 32'h12345678, 4'hF, 32'h0, 1, 2);
                drive(0, 0, 0, 0, 32'h0, 32'h0, 4'h0);
                chk("regs_a_after_errors", regs_a,
                    {32'h0, 32'h11BB33DD, 32'hDEADBEEF, 32'h0});

                // three wait states, back-to-back write then read
                t0 = cyc;
                apb_xfer(1, 1, 32'h4, 32'hCAFEF00D, 4'hF, 32'h0, 0, 5);
                apb_xfer(1, 0, 32'h4, 32'h0, 4'h0, 32'hCAFEF00D, 0, 5);
                chk("b2b_cycles", 128'(cyc - t0), 128'(12));
                drive(1, 0, 0, 0, 32'h0, 32'h0, 4'h0);
                @(posedge clk); #1;

                // abort in WAIT
                drive(1, 1, 0, 1, 32'h4, 32'h55555555, 4'hF);
                @(posedge clk); #1;
                drive(1, 1, 1, 1, 32'h4, 32'h55555555, 4'hF);
                @(posedge clk); #1;
                @(posedge clk); #1;
                drive(1, 0, 0, 0, 32'h0, 32'h0, 4'h0);
                repeat (6) begin @(posedge clk); #1; end
                chk("abort_no_change", 128'(regs_b[63:32]), 128'(32'hCAFEF00D));
                apb_xfer(1, 0, 32'h4, 32'h0, 4'h0, 32'hCAFEF00D, 0, 5);

                // reset pulse during WAIT of a write to 0xC
                apb_xfer(1, 1, 32'hC, 32'h12345678, 4'hF, 32'h0, 0, 5);
                chk("regs_b_slice3", 128'(regs_b[127:96]), 128'(32'h12345678));
                drive(1, 1, 0, 1, 32'hC, 32'hFFFFFFFF, 4'hF);
                @(posedge clk); #1;
                drive(1, 1, 1, 1, 32'hC, 32'hFFFFFFFF, 4'hF);
                @(posedge clk); #1;
                rst_b = 1'b1;
                #1;
                chk("rst_mid_pready", 128'(ifb.pready), 128'(0));
                chk("rst_mid_prdata", 128'(ifb.prdata), 128'(0));
                chk("rst_mid_regs", regs_b, 128'(0));
                #1;
                rst_b = 1'b0;
                drive(1, 0, 0, 0, 32'h0, 32'h0, 4'h0);
                @(posedge clk); #1;
                apb_xfer(1, 0, 32'hC, 32'h0, 4'h0, 32'h0, 0, 5);
                drive(1, 0, 0, 0, 32'h0, 32'h0, 4'h0);
                repeat (4) begin @(posedge clk); #1; end
                done = 1'b1;
            end
        join
        chk("queue_a_drained", 128'(qa.size()), 128'(0));
        chk("queue_b_drained", 128'(qb.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
